e203_exu_wbck_arb: RTL and testbench

- Parametrised successor to the EXU write-back arbiter.
- Arbitrates one single-cycle ALU source and NLONGP long-pipe sources (MULDIV, FPU, LSU, ...) into a BUF_DEPTH-entry write-back buffer.
- The buffer drains one entry per cycle to the integer or FP regfile write port and accumulates sticky FP exception flags.
- Sits between the EXU execution units and the regfiles; the buffer decouples EU completion from regfile-port stalls.

---
 rtl/e203_exu_wbck_arb_if.sv | 49 ++++
 rtl/e203_exu_wbck_arb.sv | 135 +++++++++++++
 tb/tb_e203_exu_wbck_arb.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/e203_exu_wbck_arb_if.sv
// Write-back arbiter bus: EU completion handshakes in, regfile write ports and
// sticky FP flags out. Parameters must match the arbiter instance.
interface e203_exu_wbck_arb_if #(
    parameter int NLONGP  = 2,
    parameter int XLEN    = 32,
    parameter int FLEN    = 32,
    parameter int RFIDX_W = 5
);
    logic                        alu_wbck_i_valid;
    logic                        alu_wbck_i_ready;
    logic [XLEN-1:0]             alu_wbck_i_wdat;
    logic [RFIDX_W-1:0]          alu_wbck_i_rdidx;
    logic [NLONGP-1:0]           longp_wbck_i_valid;
    logic [NLONGP-1:0]           longp_wbck_i_ready;
    logic [NLONGP*FLEN-1:0]      longp_wbck_i_wdat;
    logic [NLONGP*5-1:0]         longp_wbck_i_flags;
    logic [NLONGP*RFIDX_W-1:0]   longp_wbck_i_rdidx;
    logic [NLONGP-1:0]           longp_wbck_i_rdfpu;
    logic                        wbck_stall_i;
    logic                        rf_wbck_o_ena;
    logic [XLEN-1:0]             rf_wbck_o_wdat;
    logic [RFIDX_W-1:0]          rf_wbck_o_rdidx;
    logic                        frf_wbck_o_ena;
    logic [FLEN-1:0]             frf_wbck_o_wdat;
    logic [RFIDX_W-1:0]          frf_wbck_o_rdidx;
    logic [4:0]                  fflags_o;
    logic                        fflags_clr_i;
    logic                        wbck_buf_empty_o;

    modport master (
        output alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx,
        output longp_wbck_i_valid, longp_wbck_i_wdat, longp_wbck_i_flags,
        output longp_wbck_i_rdidx, longp_wbck_i_rdfpu, wbck_stall_i, fflags_clr_i,
        input  alu_wbck_i_ready, longp_wbck_i_ready,
        input  rf_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx,
        input  frf_wbck_o_ena, frf_wbck_o_wdat, frf_wbck_o_rdidx,
        input  fflags_o, wbck_buf_empty_o
    );

    modport slave (
        input  alu_wbck_i_valid, alu_wbck_i_wdat, alu_wbck_i_rdidx,
        input  longp_wbck_i_valid, longp_wbck_i_wdat, longp_wbck_i_flags,
        input  longp_wbck_i_rdidx, longp_wbck_i_rdfpu, wbck_stall_i, fflags_clr_i,
        output alu_wbck_i_ready, longp_wbck_i_ready,
        output rf_wbck_o_ena, rf_wbck_o_wdat, rf_wbck_o_rdidx,
        output frf_wbck_o_ena, frf_wbck_o_wdat, frf_wbck_o_rdidx,
        output fflags_o, wbck_buf_empty_o
    );
endinterface

// File: rtl/e203_exu_wbck_arb.sv
// EXU write-back arbiter: long-pipe sources (round-robin) win over the ALU,
// results pass through a small FIFO that drains one entry per cycle.
module e203_exu_wbck_arb #(
    parameter int NLONGP    = 2,
    parameter int XLEN      = 32,
    parameter int FLEN      = 32,
    parameter int RFIDX_W   = 5,
    parameter int BUF_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    e203_exu_wbck_arb_if.slave      wbck_if
);
    localparam int PW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW  = $clog2(BUF_DEPTH + 1);
    localparam int RRW = (NLONGP > 1) ? $clog2(NLONGP) : 1;

    typedef struct packed {
        logic [FLEN-1:0]    wdat;
        logic [4:0]         flags;
        logic [RFIDX_W-1:0] rdidx;
        logic               rdfpu;
    } entry_t;

    entry_t             ent_q [BUF_DEPTH];
    logic [PW-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]      cnt_q;
    logic [RRW-1:0]     rr_q;
    logic [4:0]         fflags_q, fflags_d;

    entry_t             head_s, wr_ent_s;
    logic               empty_s, full_s, pop_s, can_push_s, push_s, any_lp_s;
    logic [RRW-1:0]     gidx_s;
    logic [NLONGP-1:0]  grant_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(BUF_DEPTH - 1)) return '0;
        else                         return p + PW'(1);
    endfunction

    function automatic logic [RRW-1:0] rr_inc(input logic [RRW-1:0] p);
        if (p == RRW'(NLONGP - 1)) return '0;
        else                       return p + RRW'(1);
    endfunction

    assign head_s     = ent_q[rd_ptr_q];
    assign empty_s    = (cnt_q == CW'(0));
    assign full_s     = (cnt_q == CW'(BUF_DEPTH));
    assign pop_s      = ~empty_s & ~wbck_if.wbck_stall_i;
    assign can_push_s = ~full_s | pop_s;
    assign any_lp_s   = |wbck_if.longp_wbck_i_valid;

    // Round-robin scan of long-pipe valids starting at rr_q.
    always_comb begin
        logic           found;
        logic [RRW-1:0] idx;
        found   = 1'b0;
        gidx_s  = '0;
        grant_s = '0;
        for (int i = 0; i < NLONGP; i++) begin
            idx = RRW'((int'(rr_q) + i) % NLONGP);
            if (!found && wbck_if.longp_wbck_i_valid[idx]) begin
                found  = 1'b1;
                gidx_s = idx;
            end else begin
                found  = found;
            end
        end
        if (found) grant_s[gidx_s] = 1'b1;
        else       grant_s = '0;
    end

    // Select the entry to push: granted long-pipe source, else the ALU.
    always_comb begin
        wr_ent_s = '0;
        push_s   = 1'b0;
        if (any_lp_s) begin
            wr_ent_s.wdat  = wbck_if.longp_wbck_i_wdat[int'(gidx_s)*FLEN +: FLEN];
            wr_ent_s.flags = wbck_if.longp_wbck_i_flags[int'(gidx_s)*5 +: 5];
            wr_ent_s.rdidx = wbck_if.longp_wbck_i_rdidx[int'(gidx_s)*RFIDX_W +: RFIDX_W];
            wr_ent_s.rdfpu = wbck_if.longp_wbck_i_rdfpu[gidx_s];
            push_s         = can_push_s;
        end else begin
            wr_ent_s.wdat  = FLEN'(wbck_if.alu_wbck_i_wdat);
            wr_ent_s.flags = 5'd0;
            wr_ent_s.rdidx = wbck_if.alu_wbck_i_rdidx;
            wr_ent_s.rdfpu = 1'b0;
            push_s         = wbck_if.alu_wbck_i_valid & can_push_s;
        end
    end

    // Sticky flags: a same-cycle clear is applied before the popped flags.
    always_comb begin
        if (wbck_if.fflags_clr_i) fflags_d = 5'd0;
        else                      fflags_d = fflags_q;
        if (pop_s & head_s.rdfpu) fflags_d = fflags_d | head_s.flags;
        else                      fflags_d = fflags_d;
    end

    // Buffer storage, pointers, occupancy, round-robin pointer and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) ent_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            rr_q     <= '0;
            fflags_q <= 5'd0;
        end else begin
            fflags_q <= fflags_d;
            if (push_s) begin
                ent_q[wr_ptr_q] <= wr_ent_s;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_s) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push_s && any_lp_s) rr_q <= rr_inc(gidx_s);
            case ({push_s, pop_s})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign wbck_if.longp_wbck_i_ready = grant_s & {NLONGP{can_push_s}};
    assign wbck_if.alu_wbck_i_ready   = ~any_lp_s & can_push_s;
    assign wbck_if.rf_wbck_o_ena      = pop_s & ~head_s.rdfpu;
    assign wbck_if.frf_wbck_o_ena     = pop_s & head_s.rdfpu;
    assign wbck_if.rf_wbck_o_wdat     = head_s.wdat[XLEN-1:0];
    assign wbck_if.frf_wbck_o_wdat    = head_s.wdat;
    assign wbck_if.rf_wbck_o_rdidx    = head_s.rdidx;
    assign wbck_if.frf_wbck_o_rdidx   = head_s.rdidx;
    assign wbck_if.fflags_o           = fflags_q;
    assign wbck_if.wbck_buf_empty_o   = empty_s;
endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Bench for the write-back arbiter: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_e203_exu_wbck_arb;
    localparam int NLONGP = 2, XLEN = 32, FLEN = 32, RFIDX_W = 5, BUF_DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    e203_exu_wbck_arb_if #(.NLONGP(NLONGP), .XLEN(XLEN), .FLEN(FLEN), .RFIDX_W(RFIDX_W)) bus ();

    e203_exu_wbck_arb #(.NLONGP(NLONGP), .XLEN(XLEN), .FLEN(FLEN), .RFIDX_W(RFIDX_W),
                        .BUF_DEPTH(BUF_DEPTH)) dut (.clk(clk), .rst_n(rst_n), .wbck_if(bus));

    typedef struct {
        logic [FLEN-1:0]    wdat;
        logic [4:0]         flags;
        logic [RFIDX_W-1:0] rdidx;
        logic               fpu;
    } ment_t;

    ment_t       mq[$];
    int          mrr;
    logic [4:0]  mff;
    int          tests, fails;

    logic              exp_alu_rdy, exp_rf_ena, exp_frf_ena, exp_empty;
    logic [NLONGP-1:0] exp_lp_rdy;
    logic [FLEN-1:0]   exp_wdat;
    logic [RFIDX_W-1:0] exp_idx;
    logic [4:0]        exp_ff;
    bit                pred_pop, pred_cp;
    int                pred_g;

    task automatic idle();
        bus.alu_wbck_i_valid   = 1'b0;
        bus.alu_wbck_i_wdat    = '0;
        bus.alu_wbck_i_rdidx   = '0;
        bus.longp_wbck_i_valid = '0;
        bus.longp_wbck_i_wdat  = '0;
        bus.longp_wbck_i_flags = '0;
        bus.longp_wbck_i_rdidx = '0;
        bus.longp_wbck_i_rdfpu = '0;
        bus.wbck_stall_i       = 1'b0;
        bus.fflags_clr_i       = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        mrr = 0;
        mff = 5'd0;
    endtask

    // Expected outputs for the current model state and current inputs.
    task automatic predict();
        pred_pop = (mq.size() > 0) && !bus.wbck_stall_i;
        pred_cp  = (mq.size() < BUF_DEPTH) || pred_pop;
        pred_g   = -1;
        for (int i = 0; i < NLONGP; i++) begin
            int k;
            k = (mrr + i) % NLONGP;
            if (pred_g < 0 && bus.longp_wbck_i_valid[k]) pred_g = k;
        end
        exp_lp_rdy = '0;
        if (pred_g >= 0 && pred_cp) exp_lp_rdy[pred_g] = 1'b1;
        exp_alu_rdy = (pred_g < 0) && pred_cp;
        exp_rf_ena  = 1'b0;
        exp_frf_ena = 1'b0;
        exp_wdat    = '0;
        exp_idx     = '0;
        if (mq.size() > 0) begin
            exp_rf_ena  = pred_pop && !mq[0].fpu;
            exp_frf_ena = pred_pop && mq[0].fpu;
            exp_wdat    = mq[0].wdat;
            exp_idx     = mq[0].rdidx;
        end
        exp_ff    = mff;
        exp_empty = (mq.size() == 0);
    endtask

    task automatic sample();
        @(negedge clk);
        predict();
    endtask

    task automatic advance();
        ment_t e;
        logic [4:0] nff;
        @(posedge clk);
        nff = bus.fflags_clr_i ? 5'd0 : mff;
        if (pred_pop) begin
            if (mq[0].fpu) nff = nff | mq[0].flags;
            void'(mq.pop_front());
        end
        mff = nff;
        if (pred_g >= 0 && pred_cp) begin
            e.wdat  = bus.longp_wbck_i_wdat[pred_g*FLEN +: FLEN];
            e.flags = bus.longp_wbck_i_flags[pred_g*5 +: 5];
            e.rdidx = bus.longp_wbck_i_rdidx[pred_g*RFIDX_W +: RFIDX_W];
            e.fpu   = bus.longp_wbck_i_rdfpu[pred_g];
            mq.push_back(e);
            mrr = (pred_g + 1) % NLONGP;
        end else if (pred_g < 0 && bus.alu_wbck_i_valid && pred_cp) begin
            e.wdat  = FLEN'(bus.alu_wbck_i_wdat);
            e.flags = 5'd0;
            e.rdidx = bus.alu_wbck_i_rdidx;
            e.fpu   = 1'b0;
            mq.push_back(e);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        model_reset();
        #12;
        tests++; if (bus.rf_wbck_o_ena !== 1'b0) begin fails++; $display("FAIL reset_rf_ena: got %0b want 0", bus.rf_wbck_o_ena); end
        tests++; if (bus.frf_wbck_o_ena !== 1'b0) begin fails++; $display("FAIL reset_frf_ena: got %0b want 0", bus.frf_wbck_o_ena); end
        tests++; if (bus.frf_wbck_o_wdat !== 32'h0) begin fails++; $display("FAIL reset_wdat: got %h want 0", bus.frf_wbck_o_wdat); end
        tests++; if (bus.rf_wbck_o_rdidx !== 5'd0) begin fails++; $display("FAIL reset_rdidx: got %0d want 0", bus.rf_wbck_o_rdidx); end
        tests++; if (bus.wbck_buf_empty_o !== 1'b1) begin fails++; $display("FAIL reset_empty: got %0b want 1", bus.wbck_buf_empty_o); end
        tests++; if (bus.fflags_o !== 5'd0) begin fails++; $display("FAIL reset_fflags: got %h want 0", bus.fflags_o); end
        tests++; if (bus.alu_wbck_i_ready !== 1'b1) begin fails++; $display("FAIL reset_alu_ready: got %0b want 1", bus.alu_wbck_i_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        predict();
        advance();
    endtask

    task automatic test_alu();
        bus.alu_wbck_i_valid = 1'b1;
        bus.alu_wbck_i_wdat  = 32'h1234;
        bus.alu_wbck_i_rdidx = 5'd5;
        sample();
        tests++; if (bus.alu_wbck_i_ready !== 1'b1) begin fails++; $display("FAIL alu_ready: got %0b want 1", bus.alu_wbck_i_ready); end
        tests++; if (bus.rf_wbck_o_ena !== 1'b0) begin fails++; $display("FAIL alu_no_bypass: got %0b want 0", bus.rf_wbck_o_ena); end
        advance();
        idle();
        sample();
        tests++; if (bus.rf_wbck_o_ena !== 1'b1) begin fails++; $display("FAIL alu_rf_ena: got %0b want 1", bus.rf_wbck_o_ena); end
        tests++; if (bus.rf_wbck_o_wdat !== 32'h1234) begin fails++; $display("FAIL alu_rf_wdat: got %h want 1234", bus.rf_wbck_o_wdat); end
        tests++; if (bus.rf_wbck_o_rdidx !== 5'd5) begin fails++; $display("FAIL alu_rf_rdidx: got %0d want 5", bus.rf_wbck_o_rdidx); end
        tests++; if (bus.frf_wbck_o_ena !== 1'b0) begin fails++; $display("FAIL alu_frf_ena: got %0b want 0", bus.frf_wbck_o_ena); end
        advance();
    endtask

    task automatic test_priority();
        bus.alu_wbck_i_valid        = 1'b1;
        bus.alu_wbck_i_wdat         = 32'hDEAD_0001;
        bus.longp_wbck_i_valid      = 2'b10;
        bus.longp_wbck_i_wdat[32 +: 32] = 32'h3F80_0000;
        bus.longp_wbck_i_rdidx[5 +: 5]  = 5'd2;
        bus.longp_wbck_i_rdfpu      = 2'b10;
        sample();
        tests++; if (bus.longp_wbck_i_ready !== 2'b10) begin fails++; $display("FAIL prio_lp_ready: got %b want 10", bus.longp_wbck_i_ready); end
        tests++; if (bus.alu_wbck_i_ready !== 1'b0) begin fails++; $display("FAIL prio_alu_ready: got %0b want 0", bus.alu_wbck_i_ready); end
        advance();
        idle();
        sample();
        tests++; if (bus.frf_wbck_o_ena !== 1'b1) begin fails++; $display("FAIL prio_frf_ena: got %0b want 1", bus.frf_wbck_o_ena); end
        tests++; if (bus.frf_wbck_o_wdat !== 32'h3F80_0000) begin fails++; $display("FAIL prio_frf_wdat: got %h want 3f800000", bus.frf_wbck_o_wdat); end
        tests++; if (bus.frf_wbck_o_rdidx !== 5'd2) begin fails++; $display("FAIL prio_frf_rdidx: got %0d want 2", bus.frf_wbck_o_rdidx); end
        tests++; if (bus.rf_wbck_o_ena !== 1'b0) begin fails++; $display("FAIL prio_rf_ena: got %0b want 0", bus.rf_wbck_o_ena); end
        advance();
    endtask

    task automatic test_round_robin();
        logic [NLONGP-1:0] want;
        bus.longp_wbck_i_valid = 2'b11;
        for (int c = 0; c < 6; c++) begin
            bus.longp_wbck_i_wdat = {$urandom, $urandom};
            sample();
            want = (c % 2 == 0) ? 2'b01 : 2'b10;
            tests++; if (bus.longp_wbck_i_ready !== want) begin fails++; $display("FAIL rr_grant%0d: got %b want %b", c, bus.longp_wbck_i_ready, want); end
            advance();
        end
        idle();
        sample();
        advance();
    endtask

    task automatic test_back_to_back();
        bus.wbck_stall_i     = 1'b1;
        bus.alu_wbck_i_valid = 1'b1;
        bus.alu_wbck_i_wdat  = 32'hAAAA_0001; bus.alu_wbck_i_rdidx = 5'd7;
        sample(); advance();
        bus.alu_wbck_i_wdat  = 32'hBBBB_0002; bus.alu_wbck_i_rdidx = 5'd8;
        sample(); advance();
        bus.alu_wbck_i_wdat  = 32'hCCCC_0003; bus.alu_wbck_i_rdidx = 5'd9;
        sample();
        tests++; if (bus.alu_wbck_i_ready !== 1'b0) begin fails++; $display("FAIL full_alu_ready: got %0b want 0", bus.alu_wbck_i_ready); end
        tests++; if (bus.longp_wbck_i_ready !== 2'b00) begin fails++; $display("FAIL full_lp_ready: got %b want 00", bus.longp_wbck_i_ready); end
        tests++; if (bus.rf_wbck_o_ena !== 1'b0) begin fails++; $display("FAIL stall_rf_ena: got %0b want 0", bus.rf_wbck_o_ena); end
        advance();
        bus.wbck_stall_i = 1'b0;
        sample();
        tests++; if (bus.alu_wbck_i_ready !== 1'b1) begin fails++; $display("FAIL fullpop_ready: got %0b want 1", bus.alu_wbck_i_ready); end
        tests++; if (bus.rf_wbck_o_ena !== 1'b1 || bus.rf_wbck_o_wdat !== 32'hAAAA_0001 || bus.rf_wbck_o_rdidx !== 5'd7) begin fails++; $display("FAIL drain_a: got ena %0b %h/%0d want 1 aaaa0001/7", bus.rf_wbck_o_ena, bus.rf_wbck_o_wdat, bus.rf_wbck_o_rdidx); end
        advance();
        bus.alu_wbck_i_valid = 1'b0;
        sample();
        tests++; if (bus.rf_wbck_o_ena !== 1'b1 || bus.rf_wbck_o_wdat !== 32'hBBBB_0002 || bus.rf_wbck_o_rdidx !== 5'd8) begin fails++; $display("FAIL drain_b: got ena %0b %h/%0d want 1 bbbb0002/8", bus.rf_wbck_o_ena, bus.rf_wbck_o_wdat, bus.rf_wbck_o_rdidx); end
        advance();
        sample();
        tests++; if (bus.rf_wbck_o_ena !== 1'b1 || bus.rf_wbck_o_wdat !== 32'hCCCC_0003 || bus.rf_wbck_o_rdidx !== 5'd9) begin fails++; $display("FAIL drain_c: got ena %0b %h/%0d want 1 cccc0003/9", bus.rf_wbck_o_ena, bus.rf_wbck_o_wdat, bus.rf_wbck_o_rdidx); end
        advance();
        sample();
        tests++; if (bus.wbck_buf_empty_o !== 1'b1 || bus.rf_wbck_o_ena !== 1'b0) begin fails++; $display("FAIL drained_empty: got empty %0b ena %0b want 1 0", bus.wbck_buf_empty_o, bus.rf_wbck_o_ena); end
        advance();
    endtask

    task automatic test_fflags();
        idle();
        bus.fflags_clr_i = 1'b1;
        sample(); advance();
        bus.fflags_clr_i = 1'b0;
        bus.longp_wbck_i_valid = 2'b01;
        bus.longp_wbck_i_rdfpu = 2'b01;
        bus.longp_wbck_i_rdidx = 10'd3;
        bus.longp_wbck_i_flags = 10'h01;
        sample();
        tests++; if (bus.fflags_o !== 5'h00) begin fails++; $display("FAIL ff_cleared: got %h want 00", bus.fflags_o); end
        advance();
        bus.longp_wbck_i_flags = 10'h04;
        sample(); advance();
        idle();
        sample(); advance();
        sample();
        tests++; if (bus.fflags_o !== 5'h05) begin fails++; $display("FAIL ff_accum: got %h want 05", bus.fflags_o); end
        advance();
        bus.longp_wbck_i_valid = 2'b01;
        bus.longp_wbck_i_rdfpu = 2'b01;
        bus.longp_wbck_i_flags = 10'h10;
        sample(); advance();
        idle();
        bus.fflags_clr_i = 1'b1;
        sample();
        tests++; if (bus.frf_wbck_o_ena !== 1'b1) begin fails++; $display("FAIL ff_pop_ena: got %0b want 1", bus.frf_wbck_o_ena); end
        advance();
        bus.fflags_clr_i = 1'b0;
        sample();
        tests++; if (bus.fflags_o !== 5'h10) begin fails++; $display("FAIL ff_clr_pop: got %h want 10", bus.fflags_o); end
        advance();
    endtask

    task automatic test_async_reset();
        bus.wbck_stall_i     = 1'b1;
        bus.alu_wbck_i_valid = 1'b1;
        bus.alu_wbck_i_wdat  = 32'h5555_AAAA; bus.alu_wbck_i_rdidx = 5'd11;
        sample(); advance();
        bus.alu_wbck_i_rdidx = 5'd12;
        sample(); advance();
        idle();
        bus.wbck_stall_i = 1'b1;
        @(negedge clk);
        #2;
        bus.wbck_stall_i = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        tests++; if (bus.rf_wbck_o_ena !== 1'b0 || bus.frf_wbck_o_ena !== 1'b0) begin fails++; $display("FAIL arst_ena: got rf %0b frf %0b want 0 0", bus.rf_wbck_o_ena, bus.frf_wbck_o_ena); end
        tests++; if (bus.wbck_buf_empty_o !== 1'b1) begin fails++; $display("FAIL arst_empty: got %0b want 1", bus.wbck_buf_empty_o); end
        tests++; if (bus.fflags_o !== 5'd0) begin fails++; $display("FAIL arst_fflags: got %h want 0", bus.fflags_o); end
        @(negedge clk);
        rst_n = 1'b1;
        predict();
        advance();
        for (int c = 0; c < 2; c++) begin
            sample();
            tests++; if (bus.rf_wbck_o_ena !== 1'b0 || bus.wbck_buf_empty_o !== 1'b1) begin fails++; $display("FAIL arst_stale%0d: got ena %0b empty %0b want 0 1", c, bus.rf_wbck_o_ena, bus.wbck_buf_empty_o); end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bus.alu_wbck_i_valid   = 1'($urandom_range(0, 1));
            bus.alu_wbck_i_wdat    = $urandom;
            bus.alu_wbck_i_rdidx   = 5'($urandom);
            bus.longp_wbck_i_valid = 2'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            bus.longp_wbck_i_wdat  = {$urandom, $urandom};
            bus.longp_wbck_i_flags = 10'($urandom);
            bus.longp_wbck_i_rdidx = 10'($urandom);
            bus.longp_wbck_i_rdfpu = 2'($urandom);
            bus.wbck_stall_i       = ($urandom_range(0, 3) == 0);
            bus.fflags_clr_i       = ($urandom_range(0, 15) == 0);
            sample();
            tests++; if (bus.alu_wbck_i_ready !== exp_alu_rdy) begin fails++; $display("FAIL rnd_alu_ready c%0d: got %0b want %0b", c, bus.alu_wbck_i_ready, exp_alu_rdy); end
            tests++; if (bus.longp_wbck_i_ready !== exp_lp_rdy) begin fails++; $display("FAIL rnd_lp_ready c%0d: got %b want %b", c, bus.longp_wbck_i_ready, exp_lp_rdy); end
            tests++; if (bus.rf_wbck_o_ena !== exp_rf_ena || bus.frf_wbck_o_ena !== exp_frf_ena) begin fails++; $display("FAIL rnd_ena c%0d: got %0b%0b want %0b%0b", c, bus.rf_wbck_o_ena, bus.frf_wbck_o_ena, exp_rf_ena, exp_frf_ena); end
            tests++; if (bus.wbck_buf_empty_o !== exp_empty) begin fails++; $display("FAIL rnd_empty c%0d: got %0b want %0b", c, bus.wbck_buf_empty_o, exp_empty); end
            tests++; if (bus.fflags_o !== exp_ff) begin fails++; $display("FAIL rnd_fflags c%0d: got %h want %h", c, bus.fflags_o, exp_ff); end
            if (exp_rf_ena) begin
                tests++; if (bus.rf_wbck_o_wdat !== exp_wdat[XLEN-1:0] || bus.rf_wbck_o_rdidx !== exp_idx) begin fails++; $display("FAIL rnd_rf_data c%0d: got %h/%0d want %h/%0d", c, bus.rf_wbck_o_wdat, bus.rf_wbck_o_rdidx, exp_wdat[XLEN-1:0], exp_idx); end
            end
            if (exp_frf_ena) begin
                tests++; if (bus.frf_wbck_o_wdat !== exp_wdat || bus.frf_wbck_o_rdidx !== exp_idx) begin fails++; $display("FAIL rnd_frf_data c%0d: got %h/%0d want %h/%0d", c, bus.frf_wbck_o_wdat, bus.frf_wbck_o_rdidx, exp_wdat, exp_idx); end
            end
            advance();
        end
        idle();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_alu();
        test_priority();
        test_round_robin();
        test_back_to_back();
        test_fflags();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
